multi_chunk_comparator: RTL and testbench

MULTI_CHUNK_COMPARATOR -- requirements
Module: multi_chunk_comparator

---
 rtl/cmp_pkg.sv | 24 ++
 rtl/chunk_cmp.sv | 18 +
 rtl/multi_chunk_comparator.sv | 120 ++++++++++++
 tb/tb_multi_chunk_comparator.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the multi-chunk comparator: FSM state encoding,
// one-hot result-flag constants ({greater, equal, smaller}) and an index
// width helper.
package cmp_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COMPARE = 1'b1
    } state_t;

    localparam int unsigned RES_W = 3;

    // Result flags packed as {greater, equal, smaller}
    localparam logic [RES_W-1:0] RES_NONE = 3'b000;
    localparam logic [RES_W-1:0] RES_GT   = 3'b100;
    localparam logic [RES_W-1:0] RES_EQ   = 3'b010;
    localparam logic [RES_W-1:0] RES_LT   = 3'b001;

    // Chunk index width: ceil(log2(n)), never below one bit
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chunk_cmp.sv
// Combinational unsigned magnitude compare of one CHUNK-bit slice.
// Ports:
//   a, b : slice operands
//   gt   : a > b
//   lt   : a < b
module chunk_cmp #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             gt,
    output logic             lt
);

    assign gt = (a > b);
    assign lt = (a < b);

endmodule

// File: rtl/multi_chunk_comparator.sv
// Sequential magnitude comparator: walks the operands CHUNK bits per cycle,
// MSB chunk first, and stops on the first differing chunk or the last one.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   start             : request a compare (only honoured when idle)
//   x, y, signed_mode : operands and signedness, captured on accepted start
//   busy              : compare in progress
//   done              : one-cycle pulse when a new result is registered
//   greater/equal/smaller : registered result, held until the next result
module multi_chunk_comparator
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             greater,
    output logic             equal,
    output logic             smaller
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDXW   = idx_width(NCHUNK);

    // Flipping the sign bit of both operands maps two's-complement order
    // onto unsigned order.
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    state_t                     state_q, state_d;
    logic [WIDTH-1:0]           a_q, a_d, b_q, b_d;
    logic [IDXW-1:0]            idx_q, idx_d;
    logic [IDXW-1:0]            sel;
    logic                       busy_d, done_d;
    logic [RES_W-1:0]           res_q, res_d;
    logic [NCHUNK-1:0][CHUNK-1:0] a_chunks, b_chunks;
    logic                       chunk_gt, chunk_lt, last;

    assign a_chunks = a_q;
    assign b_chunks = b_q;

    // idx 0 addresses the most significant chunk
    assign sel  = IDXW'(NCHUNK - 1) - idx_q;
    assign last = (idx_q == IDXW'(NCHUNK - 1));

    chunk_cmp #(
        .CHUNK (CHUNK)
    ) u_chunk_cmp (
        .a  (a_chunks[sel]),
        .b  (b_chunks[sel]),
        .gt (chunk_gt),
        .lt (chunk_lt)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            res_q   <= RES_NONE;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            busy    <= busy_d;
            done    <= done_d;
            res_q   <= res_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        busy_d  = busy;
        done_d  = 1'b0;
        res_d   = res_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = signed_mode ? (x ^ MSB_MASK) : x;
                    b_d     = signed_mode ? (y ^ MSB_MASK) : y;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (chunk_gt || chunk_lt || last) begin
                    res_d   = chunk_gt ? RES_GT : (chunk_lt ? RES_LT : RES_EQ);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign {greater, equal, smaller} = res_q;

endmodule

// File: tb/tb_multi_chunk_comparator.sv
module tb_multi_chunk_comparator;

    localparam int unsigned W = 16;
    localparam int unsigned C = 4;
    localparam int unsigned N = W / C;

    typedef struct {
        logic [2:0] flags;
        int         due;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] x, y;
    logic         signed_mode;
    logic         busy, done, greater, equal, smaller;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t sb[$];

    multi_chunk_comparator #(.WIDTH(W), .CHUNK(C)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .x           (x),
        .y           (y),
        .signed_mode (signed_mode),
        .busy        (busy),
        .done        (done),
        .greater     (greater),
        .equal       (equal),
        .smaller     (smaller)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2:0] model_flags(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
        if (sm) begin
            if ($signed(a) > $signed(b)) return 3'b100;
            if ($signed(a) < $signed(b)) return 3'b001;
            return 3'b010;
        end
        if (a > b) return 3'b100;
        if (a < b) return 3'b001;
        return 3'b010;
    endfunction

    // Cycles in COMPARE: 1 + index of first differing chunk (MSB first), or N
    function automatic int model_k(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] d;
        d = a ^ b;
        for (int i = 0; i < N; i++) begin
            if (((d >> (W - C * (i + 1))) & 16'hF) != 16'h0) return i + 1;
        end
        return N;
    endfunction

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm, input bit hold);
        exp_t e;
        x = a; y = b; signed_mode = sm; start = 1'b1;
        @(posedge clk); #1;
        e.flags = model_flags(a, b, sm);
        e.due   = cyc + model_k(a, b);
        sb.push_back(e);
        if (!hold) start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL issue_busy: got %b want 1 (x=%h y=%h)", busy, a, b);
        end
    endtask

    task automatic wait_result(output int busy_cnt);
        exp_t e;
        bit   got;
        got = 0;
        busy_cnt = 0;
        for (int n = 0; n < 24 && !got; n++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                got = 1;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_done: got done with empty scoreboard at cycle %0d", cyc);
                end else begin
                    e = sb.pop_front();
                    if ({greater, equal, smaller} !== e.flags) begin
                        bad++;
                        $display("FAIL flags: got %b want %b", {greater, equal, smaller}, e.flags);
                    end
                    total++;
                    if (cyc != e.due) begin
                        bad++;
                        $display("FAIL latency: done at cycle %0d want %0d", cyc, e.due);
                    end
                    total++;
                    if (busy !== 1'b0) begin
                        bad++;
                        $display("FAIL busy_at_done: got %b want 0", busy);
                    end
                end
            end else if (busy === 1'b1) begin
                busy_cnt++;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL timeout: no done within budget at cycle %0d", cyc);
            if (sb.size() != 0) void'(sb.pop_front());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; x = '0; y = '0; signed_mode = 1'b0;
        #3;
        total++;
        if ({busy, done, greater, equal, smaller} !== 5'b0) begin
            bad++;
            $display("FAIL reset_state: got %b want 00000", {busy, done, greater, equal, smaller});
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({busy, done, greater, equal, smaller} !== 5'b0) begin
            bad++;
            $display("FAIL post_reset_idle: got %b want 00000", {busy, done, greater, equal, smaller});
        end
    endtask

    task automatic test_equal();
        int bc;
        issue(16'h1234, 16'h1234, 1'b0, 1'b0);
        wait_result(bc);
        total++;
        if (bc + 1 != 4) begin
            bad++;
            $display("FAIL equal_busy_cycles: got %0d want 4", bc + 1);
        end
    endtask

    task automatic test_msb();
        int bc;
        issue(16'h8000, 16'h7FFF, 1'b0, 1'b0);
        wait_result(bc);
        issue(16'h8000, 16'h7FFF, 1'b1, 1'b0);
        wait_result(bc);
    endtask

    task automatic test_mid_chunk();
        int bc;
        issue(16'h12A4, 16'h12B4, 1'b0, 1'b0);
        wait_result(bc);
    endtask

    task automatic test_ignore_busy();
        int bc;
        int spurious;
        issue(16'h0001, 16'h0000, 1'b0, 1'b0);
        x = 16'h0000; y = 16'hFFFF; signed_mode = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_result(bc);
        spurious = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) spurious++;
        end
        total++;
        if (spurious != 0) begin
            bad++;
            $display("FAIL ignore_busy_extra_done: got %0d extra pulses want 0", spurious);
        end
    endtask

    task automatic test_hold();
        int bc;
        // previous result was greater; it must survive the accepted start
        issue(16'h0000, 16'h0001, 1'b0, 1'b0);
        total++;
        if ({greater, equal, smaller} !== 3'b100) begin
            bad++;
            $display("FAIL hold_flags: got %b want 100", {greater, equal, smaller});
        end
        wait_result(bc);
    endtask

    task automatic test_reset_mid();
        int bc;
        int spurious;
        issue(16'h1200, 16'h1201, 1'b0, 1'b0);
        @(posedge clk); #4;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, greater, equal, smaller} !== 5'b0) begin
            bad++;
            $display("FAIL reset_mid_async: got %b want 00000", {busy, done, greater, equal, smaller});
        end
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) spurious++;
        end
        total++;
        if (spurious != 0) begin
            bad++;
            $display("FAIL reset_mid_done: got %0d pulses want 0", spurious);
        end
        issue(16'hFFFF, 16'h0001, 1'b1, 1'b0);
        wait_result(bc);
    endtask

    task automatic test_back_to_back();
        int   bc;
        exp_t e;
        issue(16'hA000, 16'h5000, 1'b0, 1'b1);
        wait_result(bc);
        x = 16'h3333; y = 16'h3334; signed_mode = 1'b0;
        @(posedge clk); #1;
        e.flags = model_flags(16'h3333, 16'h3334, 1'b0);
        e.due   = cyc + model_k(16'h3333, 16'h3334);
        sb.push_back(e);
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_busy: got %b want 1", busy);
        end
        wait_result(bc);
    endtask

    task automatic test_random();
        int          bc;
        logic [W-1:0] a, b;
        logic        sm;
        for (int i = 0; i < 24; i++) begin
            a  = W'($urandom);
            sm = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       b = W'($urandom);
                1:       b = a ^ (W'(1) << $urandom_range(0, W - 1));
                default: b = a;
            endcase
            issue(a, b, sm, 1'b0);
            wait_result(bc);
        end
    endtask

    initial begin
        test_reset();
        test_equal();
        test_msb();
        test_mid_chunk();
        test_ignore_busy();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
